// File: rtl/hazard_stall_unit_pkg.sv
// Shared constants and FSM state type for the hazard/stall unit.
// The FORWARDING_EN build option is handled in hazard_stall_unit.sv.
package hazard_stall_unit_pkg;

    localparam int unsigned REG_FILE_ADDR_LEN = 5;
    localparam int unsigned MULT_LAT_DEFAULT  = 4;

    typedef enum logic {
        HSU_IDLE = 1'b0,
        HSU_BUSY = 1'b1
    } hsu_state_e;

    // Keeps the counter at least 1 bit wide so MULT_LAT==1 still elaborates.
    function automatic int unsigned cnt_width(input int unsigned lat);
        return (lat > 1) ? $clog2(lat) : 1;
    endfunction

endpackage

// File: rtl/hazard_stall_unit_if.sv
// Pipeline-side view of the hazard/stall unit: ID/EX/MEM observations in,
// stall/flush controls out.
interface hazard_stall_unit_if
    import hazard_stall_unit_pkg::*;
#(
    parameter int unsigned REG_ADDR_LEN = REG_FILE_ADDR_LEN
);

    logic                    id_valid;
    logic [REG_ADDR_LEN-1:0] id_src1;
    logic [REG_ADDR_LEN-1:0] id_src2;
    logic                    id_two_src;
    logic [REG_ADDR_LEN-1:0] exe_dest;
    logic                    exe_wb_en;
    logic                    exe_mem_r_en;
    logic                    exe_mult;
    logic [REG_ADDR_LEN-1:0] mem_dest;
    logic                    mem_wb_en;
    logic                    br_taken;

    logic                    hazard_detected;
    logic                    freeze;
    logic                    ex_hold;
    logic                    flush;
    logic                    mult_busy;

    modport master (
        output id_valid, id_src1, id_src2, id_two_src,
        output exe_dest, exe_wb_en, exe_mem_r_en, exe_mult,
        output mem_dest, mem_wb_en, br_taken,
        input  hazard_detected, freeze, ex_hold, flush, mult_busy
    );

    modport slave (
        input  id_valid, id_src1, id_src2, id_two_src,
        input  exe_dest, exe_wb_en, exe_mem_r_en, exe_mult,
        input  mem_dest, mem_wb_en, br_taken,
        output hazard_detected, freeze, ex_hold, flush, mult_busy
    );

endinterface

// File: rtl/hazard_raw_cmp.sv
// One RAW comparator: does a producer (dest, en) feed a source of the ID instruction?
// Register 0 is hard-wired and never creates a dependency.
module hazard_raw_cmp #(
    parameter int unsigned ADDR_W = 5
) (
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_src1,
    input  logic [ADDR_W-1:0] id_src2,
    input  logic              id_two_src,
    input  logic [ADDR_W-1:0] dest,
    input  logic              en,
    output logic              match
);

    always_comb begin
        match = id_valid & en & (dest != '0) &
                ((dest == id_src1) | (id_two_src & (dest == id_src2)));
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// Hazard/stall unit beside ID: RAW detection, multi-cycle multiply hold, branch flush.
// Build option: define FORWARDING_EN to check RAW only against EX loads.
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int unsigned REG_ADDR_LEN = REG_FILE_ADDR_LEN,
    parameter int unsigned MULT_LAT     = MULT_LAT_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    hazard_stall_unit_if.slave  hif
);

    localparam int unsigned           CNT_W    = cnt_width(MULT_LAT);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(MULT_LAT - 1);
    localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);

    hsu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mult_stall;
    logic             ex_en;
    logic             ex_match;
    logic             mem_match;
    logic             raw_hazard;

    hazard_raw_cmp #(.ADDR_W(REG_ADDR_LEN)) u_ex_cmp (
        .id_valid   (hif.id_valid),
        .id_src1    (hif.id_src1),
        .id_src2    (hif.id_src2),
        .id_two_src (hif.id_two_src),
        .dest       (hif.exe_dest),
        .en         (ex_en),
        .match      (ex_match)
    );

    hazard_raw_cmp #(.ADDR_W(REG_ADDR_LEN)) u_mem_cmp (
        .id_valid   (hif.id_valid),
        .id_src1    (hif.id_src1),
        .id_src2    (hif.id_src2),
        .id_two_src (hif.id_two_src),
        .dest       (hif.mem_dest),
        .en         (hif.mem_wb_en),
        .match      (mem_match)
    );

`ifdef FORWARDING_EN
    // ALU results are forwarded; only a load in EX cannot be bypassed in time.
    logic unused_mem_match;
    assign ex_en            = hif.exe_wb_en & hif.exe_mem_r_en;
    assign raw_hazard       = ex_match;
    assign unused_mem_match = mem_match;
`else
    logic unused_exe_mem_r_en;
    assign ex_en               = hif.exe_wb_en;
    assign raw_hazard          = ex_match | mem_match;
    assign unused_exe_mem_r_en = hif.exe_mem_r_en;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HSU_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The final BUSY cycle does not stall: the multiply leaves EX on that edge.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mult_stall = 1'b0;
        unique case (state_q)
            HSU_IDLE: begin
                if (hif.exe_mult && (MULT_LAT > 1)) begin
                    mult_stall = 1'b1;
                    state_d    = HSU_BUSY;
                    cnt_d      = CNT_ONE;
                end
            end
            HSU_BUSY: begin
                if (cnt_q < CNT_LAST) begin
                    mult_stall = 1'b1;
                    cnt_d      = cnt_q + CNT_ONE;
                end else begin
                    state_d = HSU_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = HSU_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        hif.hazard_detected = 1'b0;
        hif.freeze          = 1'b0;
        hif.ex_hold         = 1'b0;
        hif.flush           = 1'b0;
        hif.mult_busy       = 1'b0;
        if (!rst) begin
            hif.mult_busy = (state_q != HSU_IDLE);
            if (mult_stall) begin
                hif.freeze  = 1'b1;
                hif.ex_hold = 1'b1;
            end else if (hif.br_taken) begin
                hif.flush = 1'b1;
            end else if (raw_hazard) begin
                hif.hazard_detected = 1'b1;
                hif.freeze          = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit: vector table plus multi-cycle sequences,
// expected outputs queued at drive time and popped at sample time.
module tb_hazard_stall_unit;
    import hazard_stall_unit_pkg::*;

`ifdef FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    // Expected output vectors: {hazard_detected, freeze, ex_hold, flush, mult_busy}
    localparam logic [4:0] E_NONE  = 5'b00000;
    localparam logic [4:0] E_RAW   = 5'b11000;
    localparam logic [4:0] E_MULT  = 5'b01100;
    localparam logic [4:0] E_MULTB = 5'b01101;
    localparam logic [4:0] E_BUSY  = 5'b00001;
    localparam logic [4:0] E_FLUSH = 5'b00010;
    localparam logic [4:0] E_NFRAW = FWD ? E_NONE : E_RAW;

    typedef struct {
        string      name;
        logic       rst;
        logic       iv;
        logic [4:0] s1;
        logic [4:0] s2;
        logic       two;
        logic [4:0] ed;
        logic       ewb;
        logic       eld;
        logic       emul;
        logic [4:0] md;
        logic       mwb;
        logic       br;
        logic [4:0] exp;
    } vec_t;

    typedef struct {
        string      name;
        logic [4:0] exp;
    } sb_t;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;
    sb_t  sbq[$];
    vec_t tbl[12];

    hazard_stall_unit_if #(.REG_ADDR_LEN(5)) hif ();

    hazard_stall_unit #(.REG_ADDR_LEN(5), .MULT_LAT(4)) dut (
        .clk (clk),
        .rst (rst),
        .hif (hif)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input string nm, input logic r, input logic iv,
                                input logic [4:0] s1, input logic [4:0] s2, input logic two,
                                input logic [4:0] ed, input logic ewb, input logic eld,
                                input logic emul, input logic [4:0] md, input logic mwb,
                                input logic br, input logic [4:0] ex);
        vec_t v;
        v.name = nm;  v.rst = r;   v.iv = iv;   v.s1 = s1;  v.s2 = s2;  v.two = two;
        v.ed = ed;    v.ewb = ewb; v.eld = eld; v.emul = emul;
        v.md = md;    v.mwb = mwb; v.br = br;   v.exp = ex;
        return v;
    endfunction

    task automatic check_out();
        sb_t        e;
        logic [4:0] act;
        if (sbq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_empty: no expected entry queued for this sample");
            return;
        end
        e   = sbq.pop_front();
        act = {hif.hazard_detected, hif.freeze, hif.ex_hold, hif.flush, hif.mult_busy};
        n_cmp++;
        if (act !== e.exp) begin
            n_bad++;
            $display("FAIL %s: hz/fr/eh/fl/mb got %b expected %b", e.name, act, e.exp);
        end
    endtask

    task automatic step(input vec_t v);
        @(negedge clk);
        rst              = v.rst;
        hif.id_valid     = v.iv;
        hif.id_src1      = v.s1;
        hif.id_src2      = v.s2;
        hif.id_two_src   = v.two;
        hif.exe_dest     = v.ed;
        hif.exe_wb_en    = v.ewb;
        hif.exe_mem_r_en = v.eld;
        hif.exe_mult     = v.emul;
        hif.mem_dest     = v.md;
        hif.mem_wb_en    = v.mwb;
        hif.br_taken     = v.br;
        sbq.push_back('{name: v.name, exp: v.exp});
        #2;
        check_out();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //               name            r  iv s1 s2 two ed ewb eld mul md mwb br  expected
        tbl[0]  = mk("id_invalid",       0, 0, 3, 3, 1,  3, 1,  1,  0,  3, 1,  0, E_NONE);
        tbl[1]  = mk("ld_src1",          0, 1, 3, 4, 1,  3, 1,  1,  0,  0, 0,  0, E_RAW);
        tbl[2]  = mk("ld_src2_two",      0, 1, 4, 3, 1,  3, 1,  1,  0,  0, 0,  0, E_RAW);
        tbl[3]  = mk("ld_src2_one",      0, 1, 4, 3, 0,  3, 1,  1,  0,  0, 0,  0, E_NONE);
        tbl[4]  = mk("alu_ex_src1",      0, 1, 6, 1, 0,  6, 1,  0,  0,  0, 0,  0, E_NFRAW);
        tbl[5]  = mk("alu_mem_src2",     0, 1, 2, 9, 1,  0, 0,  0,  0,  9, 1,  0, E_NFRAW);
        tbl[6]  = mk("mem_no_wb",        0, 1, 9, 9, 1,  0, 0,  0,  0,  9, 0,  0, E_NONE);
        tbl[7]  = mk("ex_r0",            0, 1, 0, 0, 1,  0, 1,  1,  0,  0, 0,  0, E_NONE);
        tbl[8]  = mk("br_over_raw_r7",   0, 1, 7, 2, 1,  7, 1,  1,  0,  7, 1,  1, E_FLUSH);
        tbl[9]  = mk("br_alone",         0, 0, 0, 0, 0,  0, 0,  0,  0,  0, 0,  1, E_FLUSH);
        tbl[10] = mk("ex_no_wb",         0, 1, 3, 3, 1,  3, 0,  1,  0,  0, 0,  0, E_NONE);
        tbl[11] = mk("mem_r0",           0, 1, 0, 5, 1,  0, 0,  0,  0,  0, 1,  0, E_NONE);

        // Reset dominates mult, branch and RAW
        step(mk("rst_all_zero_a",        1, 1, 3, 7, 1,  3, 1,  1,  1,  7, 1,  1, E_NONE));
        step(mk("rst_all_zero_b",        1, 1, 3, 7, 1,  3, 1,  1,  1,  7, 1,  1, E_NONE));

        // Mult stall from the first cycle after reset, then a back-to-back mult
        step(mk("mult_c1",               0, 0, 0, 0, 0,  0, 0,  0,  1,  0, 0,  0, E_MULT));
        step(mk("mult_c2_over_br_raw",   0, 1, 3, 0, 0,  3, 1,  1,  1,  0, 0,  1, E_MULTB));
        step(mk("mult_c3",               0, 0, 0, 0, 0,  0, 0,  0,  1,  0, 0,  0, E_MULTB));
        step(mk("mult_c4_release",       0, 0, 0, 0, 0,  0, 0,  0,  1,  0, 0,  0, E_BUSY));
        step(mk("b2b_c1",                0, 0, 0, 0, 0,  0, 0,  0,  1,  0, 0,  0, E_MULT));
        step(mk("b2b_c2",                0, 0, 0, 0, 0,  0, 0,  0,  1,  0, 0,  0, E_MULTB));
        step(mk("b2b_c3",                0, 0, 0, 0, 0,  0, 0,  0,  1,  0, 0,  0, E_MULTB));
        step(mk("b2b_c4_br",             0, 0, 0, 0, 0,  0, 0,  0,  1,  0, 0,  1, E_FLUSH | E_BUSY));
        step(mk("mult_idle_after",       0, 0, 0, 0, 0,  0, 0,  0,  0,  0, 0,  0, E_NONE));

        for (int i = 0; i < 12; i++) step(tbl[i]);

        // Load-use: load in EX, then in MEM behind the bubble, then gone
        step(mk("ld_use_c1",             0, 1, 3, 4, 1,  3, 1,  1,  0,  0, 0,  0, E_RAW));
        step(mk("ld_use_c2",             0, 1, 3, 4, 1,  0, 0,  0,  0,  3, 1,  0, E_NFRAW));
        step(mk("ld_use_c3",             0, 1, 3, 4, 1,  0, 0,  0,  0,  0, 0,  0, E_NONE));

        // ALU producer walks EX -> MEM -> out
        step(mk("alu_c1",                0, 1, 3, 0, 0,  3, 1,  0,  0,  0, 0,  0, E_NFRAW));
        step(mk("alu_c2",                0, 1, 3, 0, 0,  0, 0,  0,  0,  3, 1,  0, E_NFRAW));
        step(mk("alu_c3",                0, 1, 3, 0, 0,  0, 0,  0,  0,  0, 0,  0, E_NONE));

        // Reset while BUSY at cnt=2, then a fresh mult must start from IDLE
        step(mk("rb_c1",                 0, 0, 0, 0, 0,  0, 0,  0,  1,  0, 0,  0, E_MULT));
        step(mk("rb_c2",                 0, 0, 0, 0, 0,  0, 0,  0,  1,  0, 0,  0, E_MULTB));
        step(mk("rb_c3_rst",             1, 0, 0, 0, 0,  0, 0,  0,  1,  0, 0,  0, E_NONE));
        step(mk("rb_c4_idle",            0, 0, 0, 0, 0,  0, 0,  0,  0,  0, 0,  0, E_NONE));
        step(mk("rb_c5_restart",         0, 0, 0, 0, 0,  0, 0,  0,  1,  0, 0,  0, E_MULT));
        step(mk("rb_c6",                 0, 0, 0, 0, 0,  0, 0,  0,  1,  0, 0,  0, E_MULTB));
        step(mk("rb_c7",                 0, 0, 0, 0, 0,  0, 0,  0,  1,  0, 0,  0, E_MULTB));
        step(mk("rb_c8",                 0, 0, 0, 0, 0,  0, 0,  0,  1,  0, 0,  0, E_BUSY));
        step(mk("rb_c9",                 0, 0, 0, 0, 0,  0, 0,  0,  0,  0, 0,  0, E_NONE));

        if (sbq.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
